// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: hazard FSM state encoding and load-use depth limits.
package cpu_types_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, LU = 2'd1, MWAIT = 2'd2} haz_state_t;
  localparam int HAZ_LU_MAX = 4;
  function automatic int haz_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/haz_ctrl_if.sv
// haz_ctrl_if: bundle of hazard-controller signals; HAZ_PERF_CNT_EN adds the perf counters.
interface haz_ctrl_if #(parameter int CNT_W = 32);
  logic        nRST;
  logic [31:0] imemload_id;
  logic        memRead_ex;
  logic        memtoReg_ex;
  logic        datomic_ex;
  logic [4:0]  rt_ex;
  logic        branchSel;
  logic [1:0]  jump;
  logic        dmem_req_mem;
  logic        dhit;
  logic        stall;
  logic        flush_if;
  logic        flush_id;
  logic        flush_ex;
  logic        freeze;
  logic [1:0]  hstate;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport hc(input nRST, imemload_id, memRead_ex, memtoReg_ex, datomic_ex, rt_ex, branchSel, jump,
             dmem_req_mem, dhit, output stall, flush_if, flush_id, flush_ex, freeze, hstate, stall_cnt, flush_cnt);
  modport tb(output nRST, imemload_id, memRead_ex, memtoReg_ex, datomic_ex, rt_ex, branchSel, jump,
             dmem_req_mem, dhit, input stall, flush_if, flush_id, flush_ex, freeze, hstate, stall_cnt, flush_cnt);
`else
  localparam int unused_cnt_w = CNT_W;
  modport hc(input nRST, imemload_id, memRead_ex, memtoReg_ex, datomic_ex, rt_ex, branchSel, jump,
             dmem_req_mem, dhit, output stall, flush_if, flush_id, flush_ex, freeze, hstate);
  modport tb(output nRST, imemload_id, memRead_ex, memtoReg_ex, datomic_ex, rt_ex, branchSel, jump,
             dmem_req_mem, dhit, input stall, flush_if, flush_id, flush_ex, freeze, hstate);
`endif
  modport s1(input stall, freeze);
endinterface

// File: rtl/haz_sat_cnt.sv
// haz_sat_cnt: W-bit event counter that sticks at all-ones.
module haz_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clear_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/haz_ctrl.sv
// haz_ctrl: load-use stall, control-transfer flush and data-miss freeze control.
// Defining HAZ_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module haz_ctrl
  import cpu_types_pkg::*;
#(
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      imemload_id,
  input  logic             memRead_ex,
  input  logic             memtoReg_ex,
  input  logic             datomic_ex,
  input  logic [4:0]       rt_ex,
  input  logic             branchSel,
  input  logic [1:0]       jump,
  input  logic             dmem_req_mem,
  input  logic             dhit,
  output logic             stall,
  output logic             flush_if,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             freeze,
  output logic [1:0]       hstate
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);
  localparam int LU_N = (LU_STALL < 1) ? 1 : (LU_STALL > HAZ_LU_MAX) ? HAZ_LU_MAX : LU_STALL;
  localparam int CW = haz_cnt_w(LU_N);
  localparam logic [CW-1:0] LOAD = CW'(LU_N - 1);
  haz_state_t state_q, state_d, ret_q, ret_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hz, ctrl, frz, stall_c, flush_c;
  logic unused_bits;
  assign unused_bits = ^{imemload_id[31:26], imemload_id[15:0]};
  assign hz = (memRead_ex | (datomic_ex & memtoReg_ex)) & (rt_ex != 5'd0) &
              (rt_ex == imemload_id[25:21] | rt_ex == imemload_id[20:16]);
  assign ctrl = branchSel | (jump != 2'b00);
  assign frz = dmem_req_mem & ~dhit;
  // Freeze outranks everything; the cycle dhit returns only restores, hazards are re-evaluated after.
  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    cnt_d = cnt_q;
    stall_c = 1'b0;
    flush_c = 1'b0;
    if (frz) begin
      state_d = MWAIT;
      ret_d = (state_q == MWAIT) ? ret_q : state_q;
    end else if (state_q == MWAIT) begin
      flush_c = ctrl;
      state_d = ctrl ? RUN : ret_q;
      cnt_d = ctrl ? '0 : cnt_q;
      ret_d = RUN;
    end else if (ctrl) begin
      flush_c = 1'b1;
      state_d = RUN;
      cnt_d = '0;
    end else if (state_q == LU) begin
      stall_c = 1'b1;
      cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
      state_d = (cnt_q <= CW'(1)) ? RUN : LU;
    end else if (hz) begin
      stall_c = 1'b1;
      cnt_d = LOAD;
      state_d = (LU_N > 1) ? LU : RUN;
    end
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q <= RUN;
      ret_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      cnt_q <= cnt_d;
    end
  assign stall = nRST & stall_c;
  assign flush_ex = nRST & stall_c;
  assign flush_if = nRST & flush_c;
  assign flush_id = nRST & flush_c;
  assign freeze = nRST & frz;
  assign hstate = nRST ? 2'(state_q) : 2'b00;
`ifdef HAZ_PERF_CNT_EN
  haz_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk(CLK), .rst_n(nRST), .inc_i(stall_c & ~frz), .clear_i(1'b0), .cnt_o(stall_cnt)
  );
  haz_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk(CLK), .rst_n(nRST), .inc_i(flush_c & ~frz), .clear_i(1'b0), .cnt_o(flush_cnt)
  );
`else
  localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_haz_ctrl.sv
// tb_haz_ctrl: three controllers (LU_STALL 1, 3, 4) on shared stimulus, checked against a bubble-count model.
module tb_haz_ctrl;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic [31:0] imem;
  logic memRead, memtoReg, datomic, branchSel, dreq, dhit;
  logic [4:0] rt_ex;
  logic [1:0] jump;
  logic [2:0] stall_v, fif_v, fid_v, fex_v, frz_v;
  logic [1:0] hs[3];
  logic [3:0] scnt[3], fcnt[3];
  int tests = 0, fails = 0;
  int rem[3], n_rem[3], sc[3], n_sc[3], fc[3], n_fc[3];
  bit pf[3], n_pf[3];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    haz_ctrl #(.LU_STALL(g == 0 ? 1 : (g == 1 ? 3 : 4)), .CNT_W(4)) u (
      .CLK(CLK), .nRST(nRST), .imemload_id(imem), .memRead_ex(memRead), .memtoReg_ex(memtoReg),
      .datomic_ex(datomic), .rt_ex(rt_ex), .branchSel(branchSel), .jump(jump),
      .dmem_req_mem(dreq), .dhit(dhit), .stall(stall_v[g]), .flush_if(fif_v[g]), .flush_id(fid_v[g]),
      .flush_ex(fex_v[g]), .freeze(frz_v[g]), .hstate(hs[g])
`ifdef HAZ_PERF_CNT_EN
      , .stall_cnt(scnt[g]), .flush_cnt(fcnt[g])
`endif
    );
`ifndef HAZ_PERF_CNT_EN
    assign scnt[g] = 4'd0;
    assign fcnt[g] = 4'd0;
`endif
  end

  function automatic int lu_of(input int i);
    return i == 0 ? 1 : (i == 1 ? 3 : 4);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: rem = bubbles still owed after the hazard cycle; pf = previous cycle was frozen.
  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      bit fz, ct, hz, es, ef, ez;
      int eh;
      fz = dreq && !dhit;
      ct = branchSel || jump != 2'b00;
      hz = (memRead || (datomic && memtoReg)) && rt_ex != 0 && (rt_ex == imem[25:21] || rt_ex == imem[20:16]);
      es = 0; ef = 0; ez = 0; eh = 0;
      n_rem[i] = rem[i];
      n_pf[i] = 0;
      if (!nRST) n_rem[i] = 0;
      else if (fz) begin ez = 1; eh = pf[i] ? 2 : (rem[i] > 0 ? 1 : 0); n_pf[i] = 1; end
      else if (pf[i]) begin eh = 2; ef = ct; if (ct) n_rem[i] = 0; end
      else if (ct) begin ef = 1; eh = rem[i] > 0 ? 1 : 0; n_rem[i] = 0; end
      else if (rem[i] > 0) begin es = 1; eh = 1; n_rem[i] = rem[i] - 1; end
      else if (hz) begin es = 1; n_rem[i] = lu_of(i) - 1; end
      chk($sformatf("u%0d.stall", i), stall_v[i], es);
      chk($sformatf("u%0d.flush_ex", i), fex_v[i], es);
      chk($sformatf("u%0d.flush_if", i), fif_v[i], ef);
      chk($sformatf("u%0d.flush_id", i), fid_v[i], ef);
      chk($sformatf("u%0d.freeze", i), frz_v[i], ez);
      chk($sformatf("u%0d.hstate", i), hs[i], eh);
`ifdef HAZ_PERF_CNT_EN
      chk($sformatf("u%0d.stall_cnt", i), scnt[i], nRST ? sc[i] : 0);
      chk($sformatf("u%0d.flush_cnt", i), fcnt[i], nRST ? fc[i] : 0);
`endif
      n_sc[i] = !nRST ? 0 : (sc[i] + int'(es) > 15 ? 15 : sc[i] + int'(es));
      n_fc[i] = !nRST ? 0 : (fc[i] + int'(ef) > 15 ? 15 : fc[i] + int'(ef));
    end
  end

  always @(posedge CLK)
    for (int i = 0; i < 3; i++) begin
      rem[i] <= n_rem[i];
      pf[i] <= n_pf[i];
      sc[i] <= n_sc[i];
      fc[i] <= n_fc[i];
    end

  task automatic idle();
    imem = 32'd0; memRead = 0; memtoReg = 0; datomic = 0; rt_ex = 5'd0;
    branchSel = 0; jump = 2'b00; dreq = 0; dhit = 0;
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_hz(input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rtid);
    idle();
    memRead = 1;
    rt_ex = rt;
    imem = {6'h23, rs, rtid, 16'h0010};
  endtask

  task automatic drain();
    idle();
    repeat (5) nxt();
  endtask

  initial begin
    idle();
    @(negedge CLK);
    chk("rst.stall", stall_v, 0);
    chk("rst.hstate", hs[2], 0);
    nxt(); nRST = 1;
    // load-use bubbles: 1, 3 and 4 cycles
    nxt(); load_hz(5'd5, 5'd5, 5'd0);
    @(negedge CLK); chk("lu.c0.stall", stall_v, 3'b111); chk("lu.c0.fex", fex_v, 3'b111); chk("lu.c0.hs1", hs[1], 0);
    nxt(); idle();
    @(negedge CLK); chk("lu.c1.stall", stall_v, 3'b110); chk("lu.c1.hs0", hs[0], 0); chk("lu.c1.hs1", hs[1], 1);
    nxt(); @(negedge CLK); chk("lu.c2.stall", stall_v, 3'b110); chk("lu.c2.hs1", hs[1], 1);
    nxt(); @(negedge CLK); chk("lu.c3.stall", stall_v, 3'b100); chk("lu.c3.hs1", hs[1], 0); chk("lu.c3.hs2", hs[2], 1);
    nxt(); @(negedge CLK); chk("lu.c4.stall", stall_v, 3'b000); chk("lu.c4.hs2", hs[2], 0);
    // branch beats hazard
    nxt(); load_hz(5'd5, 5'd5, 5'd0); branchSel = 1;
    @(negedge CLK); chk("br.fif", fif_v, 3'b111); chk("br.fid", fid_v, 3'b111); chk("br.stall", stall_v, 0); chk("br.fex", fex_v, 0);
    nxt(); idle(); @(negedge CLK); chk("br.after", stall_v, 0);
    // r0 never a hazard
    nxt(); load_hz(5'd0, 5'd0, 5'd9); @(negedge CLK); chk("r0.stall", stall_v, 0);
    // rt-field match
    nxt(); load_hz(5'd9, 5'd1, 5'd9); @(negedge CLK); chk("rt.stall", stall_v, 3'b111);
    drain();
    // atomic writeback-from-memory counts as a load; atomic alone does not
    nxt(); idle(); datomic = 1; memtoReg = 1; rt_ex = 5'd7; imem = {6'h0, 5'd7, 5'd2, 16'h0};
    @(negedge CLK); chk("at.stall", stall_v, 3'b111);
    drain();
    nxt(); datomic = 1; memtoReg = 0; rt_ex = 5'd7; imem = {6'h0, 5'd7, 5'd2, 16'h0};
    @(negedge CLK); chk("at.nomtr", stall_v, 0);
    // freeze in LU, resume with remaining bubbles
    nxt(); load_hz(5'd5, 5'd5, 5'd0);
    nxt(); idle(); @(negedge CLK); chk("mw.c1.hs1", hs[1], 1);
    nxt(); dreq = 1; @(negedge CLK); chk("mw.c2.frz", frz_v, 3'b111); chk("mw.c2.stall", stall_v, 0);
    nxt(); @(negedge CLK); chk("mw.c3.hs1", hs[1], 2); chk("mw.c3.hs0", hs[0], 2);
    nxt(); nxt(); @(negedge CLK); chk("mw.c5.frz", frz_v, 3'b111);
    nxt(); dhit = 1; @(negedge CLK); chk("mw.c6.frz", frz_v, 0); chk("mw.c6.stall", stall_v, 0); chk("mw.c6.hs1", hs[1], 2);
    nxt(); idle(); @(negedge CLK); chk("mw.c7.stall", stall_v, 3'b110); chk("mw.c7.hs1", hs[1], 1);
    nxt(); @(negedge CLK); chk("mw.c8.stall", stall_v, 3'b100);
    nxt(); @(negedge CLK); chk("mw.c9.stall", stall_v, 0);
    // jump aborts LU
    nxt(); load_hz(5'd5, 5'd5, 5'd0);
    nxt(); idle(); jump = 2'b01; @(negedge CLK); chk("ab.fif", fif_v, 3'b111); chk("ab.stall", stall_v, 0); chk("ab.hs2", hs[2], 1);
    nxt(); idle(); @(negedge CLK); chk("ab.after", stall_v, 0); chk("ab.hs2b", hs[2], 0);
    // branch in the dhit cycle cancels the saved LU
    nxt(); load_hz(5'd5, 5'd5, 5'd0);
    nxt(); idle(); dreq = 1;
    nxt(); dhit = 1; branchSel = 1; @(negedge CLK); chk("rb.fif", fif_v, 3'b111);
    nxt(); idle(); @(negedge CLK); chk("rb.stall", stall_v, 0); chk("rb.hs1", hs[1], 0);
    // freeze masks a hazard which is re-evaluated after dhit
    nxt(); load_hz(5'd5, 5'd5, 5'd0); dreq = 1; @(negedge CLK); chk("fh.stall", stall_v, 0);
    nxt(); dhit = 1; @(negedge CLK); chk("fh.rel", stall_v, 0);
    nxt(); dreq = 0; dhit = 0; @(negedge CLK); chk("fh.re", stall_v, 3'b111);
    drain();
    // reset during LU
    nxt(); load_hz(5'd5, 5'd5, 5'd0);
    nxt(); idle(); nRST = 0; #1;
    chk("rl.stall", stall_v, 0); chk("rl.hs2", hs[2], 0);
`ifdef HAZ_PERF_CNT_EN
    chk("rl.scnt", scnt[2], 0);
`endif
    nxt(); nRST = 1; @(negedge CLK); chk("rl.after", stall_v, 0); chk("rl.hs2b", hs[2], 0);
    // reset during MWAIT
    nxt(); load_hz(5'd5, 5'd5, 5'd0);
    nxt(); idle(); dreq = 1;
    nxt(); nRST = 0;
    nxt(); idle(); nRST = 1; @(negedge CLK); chk("rm.stall", stall_v, 0); chk("rm.hs1", hs[1], 0);
    // flush counter saturation, with some frozen branch cycles
    nxt(); branchSel = 1; dreq = 1;
    nxt(); nxt(); dreq = 0;
    repeat (20) nxt();
`ifdef HAZ_PERF_CNT_EN
    @(negedge CLK); chk("sat.fcnt", fcnt[0], 15);
`endif
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/haz_ctrl.md
HAZ_CTRL -- requirements
Module: haz_ctrl

Interface
REQ-001 SHALL have parameter LU_STALL, default 1, load-use bubble cycles inserted per hazard (legal 1..4).
REQ-002 SHALL have parameter CNT_W, default 32, performance counter width.
REQ-003 SHALL have port CLK  input  1  single clock, rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imemload_id  input  32  instruction in ID; rs = [25:21], rt = [20:16].
REQ-006 SHALL have ports memRead_ex, memtoReg_ex, datomic_ex  input  1 each  EX-stage load / writeback-from-memory / atomic flags.
REQ-007 SHALL have port rt_ex  input  5  EX-stage load destination register.
REQ-008 SHALL have ports branchSel  input  1 (taken branch resolved) and jump  input  2 (nonzero = jump).
REQ-009 SHALL have ports dmem_req_mem  input  1 (MEM data request) and dhit  input  1 (data returned).
REQ-010 SHALL have outputs stall, flush_if, flush_id, flush_ex, freeze  1 each.
REQ-011 SHALL have output hstate  2  current FSM state (RUN=0, LU=1, MWAIT=2).

Function
REQ-012 Load hazard SHALL be (memRead_ex | (datomic_ex & memtoReg_ex)) & rt_ex!=0 & (rt_ex==rs or rt_ex==rt).
REQ-013 In RUN, a load hazard SHALL assert stall and flush_ex in the same cycle, load counter with LU_STALL-1, and move to LU if LU_STALL>1.
REQ-014 In LU, stall and flush_ex SHALL stay high; counter decrements per unfrozen cycle; at counter 0 SHALL return to RUN next edge, giving exactly LU_STALL stall cycles total.
REQ-015 Control transfer (branchSel | jump!=0) SHALL assert flush_if and flush_id combinationally in the same cycle.
REQ-016 Control transfer simultaneous with a load hazard SHALL win: no stall, counter not loaded, state stays RUN.
REQ-017 Control transfer while in LU SHALL abort LU: flushes asserted, stall low, next state RUN.
REQ-018 dmem_req_mem & !dhit SHALL assert freeze combinationally and, in the same cycle, force stall, flush_if, flush_id and flush_ex low.
REQ-019 While frozen, the FSM SHALL enter/stay MWAIT, saving the return state (RUN or LU) and the counter unchanged.
REQ-020 In MWAIT, dhit high SHALL deassert freeze that cycle and restore the saved state and counter next edge; pending hazards re-evaluate then.
REQ-021 Counter SHALL be ceil(log2(LU_STALL+1)) bits wide, never underflow.

Reset
REQ-022 nRST low SHALL immediately force state RUN, counter 0, saved state RUN, perf counters 0.
REQ-023 All outputs SHALL be 0 while nRST is low; hstate SHALL read 0.
REQ-024 Reset mid-LU or mid-MWAIT SHALL discard the pending operation; no stall persists after release.

Configuration
REQ-025 Macro HAZ_PERF_CNT_EN defined SHALL add outputs stall_cnt and flush_cnt (CNT_W each), counting cycles with stall high and with flush_if high, saturating at all-ones, frozen while freeze high.
REQ-026 Macro HAZ_PERF_CNT_EN undefined SHALL remove those ports and registers; all other behaviour identical.

Structure
REQ-027 Enum haz_state_t (RUN, LU, MWAIT) and localparam HAZ_LU_MAX=4 SHALL live in cpu_types_pkg.
REQ-028 Interface haz_ctrl_if SHALL carry all non-clock ports with modports hc, tb, and s1 (stall, freeze inputs only).
REQ-029 Sub-module haz_sat_cnt (parameter W, inc, clear, saturating) SHALL implement each perf counter.

Verification
REQ-030 LU_STALL=1, rt_ex=5, memRead_ex=1, imemload_id rs=5 -> stall, flush_ex high exactly 1 cycle, hstate stays 0.
REQ-031 LU_STALL=3, same hazard -> stall high 3 consecutive cycles, hstate 0,1,1 then 0.
REQ-032 Hazard plus branchSel=1 same cycle -> flush_if=flush_id=1, stall=0, flush_ex=0.
REQ-033 LU_STALL=3, in LU with counter 1, dmem_req_mem=1, dhit=0 for 4 cycles -> freeze high 4 cycles, hstate 2, then 1 remaining stall cycle after dhit.
REQ-034 rt_ex=0, memRead_ex=1, rs=0 -> no stall.
REQ-035 nRST pulsed low during LU (LU_STALL=4) -> outputs 0 immediately, hstate 0; with HAZ_PERF_CNT_EN, stall_cnt=0.
